// File: rtl/y_risc_pkg.sv
// Shared memory-path types: access sizes, byte-enable constants and the
// buffered store entry layout used by the store and load paths.
package y_risc_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } mem_size_e;

  localparam logic [3:0] BE_ALL   = 4'b1111;
  localparam int         ENTRY_AW = 32;

  // Widest supported byte address; narrower ADDR_W values are zero-extended.
  typedef struct packed {
    logic [ENTRY_AW-1:0] addr;
    logic [31:0]         data;
    logic [3:0]          be;
  } store_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Core store port, memory write port and load-hazard probe of the store buffer.
interface store_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 3
);
    // Both ports use strict valid/ready: a transfer happens on a rising edge
    // where valid and ready are both 1; ready never depends on valid.
    logic              store_valid_i;
    logic              store_ready_o;
    logic [ADDR_W-1:0] store_addr_i;
    logic [31:0]       store_data_i;
    logic [1:0]        store_size_i;
    logic              misalign_o;
    logic              mem_write_en_o;
    logic              mem_write_ready_i;
    logic [ADDR_W-1:0] mem_write_addr_o;
    logic [31:0]       mem_write_data_o;
    logic [3:0]        mem_write_be_o;
    logic [ADDR_W-1:0] load_addr_i;
    logic              load_hazard_o;
    logic              empty_o;
    logic [CNT_W-1:0]  count_o;

    modport slave (
        input  store_valid_i, store_addr_i, store_data_i, store_size_i,
        input  mem_write_ready_i, load_addr_i,
        output store_ready_o, misalign_o, mem_write_en_o, mem_write_addr_o,
        output mem_write_data_o, mem_write_be_o, load_hazard_o, empty_o, count_o
    );

    modport master (
        output store_valid_i, store_addr_i, store_data_i, store_size_i,
        output mem_write_ready_i, load_addr_i,
        input  store_ready_o, misalign_o, mem_write_en_o, mem_write_addr_o,
        input  mem_write_data_o, mem_write_be_o, load_hazard_o, empty_o, count_o
    );
endinterface

// File: rtl/store_align.sv
// Combinational size/offset decode: byte enables, lane-replicated data and
// a misalignment flag. Shared with the load path for lane extraction.
module store_align
    import y_risc_pkg::*;
(
    input  mem_size_e   size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data_i,
    output logic [3:0]  be_o,
    output logic [31:0] data_o,
    output logic        misalign_o
);
    always_comb begin
        be_o       = '0;
        data_o     = data_i;
        misalign_o = 1'b0;
        case (size_i)
            SIZE_B: begin
                be_o   = 4'b0001 << addr_lo_i;
                data_o = {4{data_i[7:0]}};
            end
            SIZE_H: begin
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                data_o     = {2{data_i[15:0]}};
                misalign_o = addr_lo_i[0];
            end
            SIZE_W: begin
                be_o       = BE_ALL;
                misalign_o = |addr_lo_i;
            end
            default: misalign_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/store_buffer.sv
// Store buffer: aligns core stores, queues them in a small FIFO and drains
// one per cycle to memory; flags loads that hit a pending store word.
module store_buffer
    import y_risc_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    store_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    store_entry_t     buf_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             misalign_q;

    logic [3:0]  al_be;
    logic [31:0] al_data;
    logic        al_bad;
    logic        full, empty, accept, push, pop;

    store_align u_align (
        .size_i     (mem_size_e'(bus.store_size_i)),
        .addr_lo_i  (bus.store_addr_i[1:0]),
        .data_i     (bus.store_data_i),
        .be_o       (al_be),
        .data_o     (al_data),
        .misalign_o (al_bad)
    );

    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    assign accept = bus.store_valid_i && !full;
    // Bad requests complete the handshake but never occupy a slot.
    assign push   = accept && !al_bad;
    assign pop    = !empty && bus.mem_write_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= accept && al_bad;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset: validity is tracked by count and pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_q[wr_ptr_q].addr <= ENTRY_AW'({bus.store_addr_i[ADDR_W-1:2], 2'b00});
            buf_q[wr_ptr_q].data <= al_data;
            buf_q[wr_ptr_q].be   <= al_be;
        end
    end

    // Head outputs are gated so they read as zero whenever nothing is pending.
    assign bus.mem_write_en_o   = !empty;
    assign bus.mem_write_addr_o = empty ? '0 : ADDR_W'(buf_q[rd_ptr_q].addr);
    assign bus.mem_write_data_o = empty ? '0 : buf_q[rd_ptr_q].data;
    assign bus.mem_write_be_o   = empty ? '0 : buf_q[rd_ptr_q].be;
    assign bus.store_ready_o    = !full;
    assign bus.empty_o          = empty;
    assign bus.count_o          = count_q;
    assign bus.misalign_o       = misalign_q;

    // Word-granular match against every occupied slot, including one popping now.
    always_comb begin
        logic [PTR_W-1:0]  offset;
        logic [ADDR_W-1:0] diff;
        bus.load_hazard_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr_q;
            diff   = (ADDR_W'(buf_q[i].addr) ^ bus.load_addr_i) & ~ADDR_W'(3);
            if ((CNT_W'(offset) < count_q) && (diff == '0))
                bus.load_hazard_o = 1'b1;
        end
    end
endmodule
